// File: rtl/rob_pkg.sv
// Shared types and helpers for the reorder buffer and other retire-side
// queues (the load/store queue retire logic uses the same helpers).
//   rob_flags_t        : per-entry control state (valid, done, exc)
//   first_zero_therm() : keeps the bits below the first zero of a lane mask
//   popcount()         : number of set bits in a lane mask
// Lane masks are passed zero-extended to LANE_MAX bits so a single function
// serves every lane count; callers cast the result back to their width.
package rob_pkg;

  localparam int unsigned LANE_MAX = 32;

  typedef logic [LANE_MAX-1:0] lane_vec_t;

  typedef struct packed {
    logic valid;
    logic done;
    logic exc;
  } rob_flags_t;

  function automatic lane_vec_t first_zero_therm(input lane_vec_t v);
    lane_vec_t t;
    t[0] = v[0];
    for (int i = 1; i < LANE_MAX; i++) t[i] = t[i-1] & v[i];
    return t;
  endfunction

  function automatic logic [5:0] popcount(input lane_vec_t v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < LANE_MAX; i++) c = c + 6'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/rob_commit_select.sv
// In-order retire selection over the NW entries starting at head.
//   lane_flags   : control state of entries head+0 .. head+NW-1
//   commit_valid : thermometer mask of lanes that retire this cycle
//   ncommit      : popcount of commit_valid
//   exc_take     : the head entry is finished and carries an exception
// Purely combinational; shared with the load/store queue retire logic.
module rob_commit_select
  import rob_pkg::*;
#(
  parameter int NW    = 4,
  parameter int CNT_W = $clog2(NW + 1)
) (
  input  rob_flags_t [NW-1:0] lane_flags,
  output logic [NW-1:0]       commit_valid,
  output logic [CNT_W-1:0]    ncommit,
  output logic                exc_take
);

  logic [NW-1:0] lane_ok;

  always_comb begin
    lane_ok = '0;
    for (int i = 0; i < NW; i++)
      lane_ok[i] = lane_flags[i].valid & lane_flags[i].done & ~lane_flags[i].exc;
    // A faulting head entry has lane_ok[0]=0, so the thermometer is empty
    // in exactly the cycle the exception is reported.
    commit_valid = NW'(first_zero_therm(lane_vec_t'(lane_ok)));
    ncommit      = CNT_W'(popcount(lane_vec_t'(commit_valid)));
    exc_take     = lane_flags[0].valid & lane_flags[0].done & lane_flags[0].exc;
  end

endmodule

// File: rtl/rob_param.sv
// Parametrised reorder buffer: holds renamed instructions in program order
// between dispatch and retirement.
//   clk, reset                      : clock, synchronous active-high reset
//   disp_valid/arch/phys/op         : NW-lane dispatch (lanes past first 0 ignored)
//   disp_ready, disp_idx            : room for NW entries; index per lane (tail+i)
//   wb_valid/idx/exc                : NWB writeback ports (dropped on invalid entries)
//   squash_valid, squash_idx        : keep up to squash_idx, discard younger
//   commit_valid/arch/phys          : thermometer retire mask with mappings
//   exc_valid, exc_idx, exc_op      : precise exception at head; ROB flushes next edge
//   count, empty, full              : occupancy
module rob_param
  import rob_pkg::*;
#(
  parameter int DEPTH  = 128,
  parameter int NW     = 4,
  parameter int NWB    = 4,
  parameter int ARCH_W = 5,
  parameter int PHYS_W = 8,
  parameter int OP_W   = 11,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NW-1:0]       disp_valid,
  input  logic [NW*ARCH_W-1:0] disp_arch,
  input  logic [NW*PHYS_W-1:0] disp_phys,
  input  logic [NW*OP_W-1:0]  disp_op,
  output logic                disp_ready,
  output logic [NW*IDX_W-1:0] disp_idx,
  input  logic [NWB-1:0]      wb_valid,
  input  logic [NWB*IDX_W-1:0] wb_idx,
  input  logic [NWB-1:0]      wb_exc,
  input  logic                squash_valid,
  input  logic [IDX_W-1:0]    squash_idx,
  output logic [NW-1:0]       commit_valid,
  output logic [NW*ARCH_W-1:0] commit_arch,
  output logic [NW*PHYS_W-1:0] commit_phys,
  output logic                exc_valid,
  output logic [IDX_W-1:0]    exc_idx,
  output logic [OP_W-1:0]     exc_op,
  output logic [IDX_W:0]      count,
  output logic                empty,
  output logic                full
);

  localparam int CNT_W = $clog2(NW + 1);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [IDX_W:0]   ptr_t;   // extra MSB is the wrap bit

  // Control state is reset; payload storage is not.
  rob_flags_t        flags    [DEPTH];
  logic [ARCH_W-1:0] arch_mem [DEPTH];
  logic [PHYS_W-1:0] phys_mem [DEPTH];
  logic [OP_W-1:0]   op_mem   [DEPTH];
  ptr_t              head, tail;

  idx_t                 head_idx, tail_idx, sq_rel;
  idx_t                 lane_idx   [NW];
  rob_flags_t [NW-1:0]  lane_flags;
  logic [CNT_W-1:0]     ncommit, ndisp;
  logic [NW-1:0]        disp_mask;
  logic                 exc_take, disp_fire;
  logic [DEPTH-1:0]     wb_done_set, wb_exc_set, kill;

  assign head_idx   = head[IDX_W-1:0];
  assign tail_idx   = tail[IDX_W-1:0];
  assign count      = tail - head;
  assign empty      = (count == '0);
  assign full       = (count == ptr_t'(DEPTH));
  assign disp_ready = (count <= ptr_t'(DEPTH - NW));

  // Retire view: NW entries from head, wrapping mod DEPTH.
  always_comb begin
    commit_arch = '0;
    commit_phys = '0;
    for (int i = 0; i < NW; i++) begin
      lane_idx[i]   = head_idx + idx_t'(i);
      lane_flags[i] = flags[lane_idx[i]];
      commit_arch[i*ARCH_W +: ARCH_W] = arch_mem[lane_idx[i]];
      commit_phys[i*PHYS_W +: PHYS_W] = phys_mem[lane_idx[i]];
    end
  end

  rob_commit_select #(.NW(NW), .CNT_W(CNT_W)) u_commit_select (
    .lane_flags   (lane_flags),
    .commit_valid (commit_valid),
    .ncommit      (ncommit),
    .exc_take     (exc_take)
  );

  assign exc_valid = exc_take;
  assign exc_idx   = head_idx;
  assign exc_op    = op_mem[head_idx];

  // Dispatch: only the contiguous run of lanes starting at lane 0 is taken.
  assign disp_mask = NW'(first_zero_therm(lane_vec_t'(disp_valid)));
  assign ndisp     = CNT_W'(popcount(lane_vec_t'(disp_mask)));
  assign disp_fire = disp_ready & disp_valid[0] & ~exc_take & ~squash_valid;

  always_comb begin
    disp_idx = '0;
    for (int i = 0; i < NW; i++) disp_idx[i*IDX_W +: IDX_W] = tail_idx + idx_t'(i);
  end

  // Writeback ports OR-merged per entry so same-index hits never race.
  always_comb begin
    wb_done_set = '0;
    wb_exc_set  = '0;
    for (int p = 0; p < NWB; p++) begin
      if (wb_valid[p] && flags[wb_idx[p*IDX_W +: IDX_W]].valid) begin
        wb_done_set[wb_idx[p*IDX_W +: IDX_W]] = 1'b1;
        wb_exc_set[wb_idx[p*IDX_W +: IDX_W]]  = wb_exc_set[wb_idx[p*IDX_W +: IDX_W]] | wb_exc[p];
      end
    end
  end

  // Squash keeps entries whose age relative to head is <= squash_idx's age.
  assign sq_rel = squash_idx - head_idx;

  always_comb begin
    kill = '0;
    for (int j = 0; j < DEPTH; j++)
      kill[j] = squash_valid && (idx_t'(idx_t'(j) - head_idx) > sq_rel);
  end

  // Control state: later assignments in this block take precedence, which
  // orders writeback < commit clear < flush/squash invalidate < dispatch.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < DEPTH; j++) flags[j] <= '0;
      head <= '0;
      tail <= '0;
    end else begin
      for (int j = 0; j < DEPTH; j++) begin
        if (wb_done_set[j]) flags[j].done <= 1'b1;
        if (wb_exc_set[j])  flags[j].exc  <= 1'b1;
      end
      for (int i = 0; i < NW; i++)
        if (commit_valid[i]) flags[lane_idx[i]] <= '0;

      if (exc_take) begin
        for (int j = 0; j < DEPTH; j++) flags[j].valid <= 1'b0;
        tail <= head;
      end else if (squash_valid) begin
        for (int j = 0; j < DEPTH; j++)
          if (kill[j]) flags[j].valid <= 1'b0;
        // Deriving tail from head keeps the wrap bit consistent (count <= DEPTH).
        tail <= head + ptr_t'(sq_rel) + ptr_t'(1);
        head <= head + ptr_t'(ncommit);
      end else begin
        head <= head + ptr_t'(ncommit);
        if (disp_fire) begin
          for (int i = 0; i < NW; i++)
            if (disp_mask[i]) flags[tail_idx + idx_t'(i)] <= '{valid: 1'b1, done: 1'b0, exc: 1'b0};
          tail <= tail + ptr_t'(ndisp);
        end
      end
    end
  end

  // Payload storage
  always_ff @(posedge clk) begin
    if (disp_fire) begin
      for (int i = 0; i < NW; i++) begin
        if (disp_mask[i]) begin
          arch_mem[tail_idx + idx_t'(i)] <= disp_arch[i*ARCH_W +: ARCH_W];
          phys_mem[tail_idx + idx_t'(i)] <= disp_phys[i*PHYS_W +: PHYS_W];
          op_mem[tail_idx + idx_t'(i)]   <= disp_op[i*OP_W +: OP_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_rob_param.sv
// Scoreboard bench for rob_param (DEPTH=16, NW=4, NWB=4).
// Dispatches push expected retire records; a negedge monitor pops them as
// the DUT retires or raises an exception. Directed checks cover status.
module tb_rob_param;

  localparam int DEPTH = 16, NW = 4, NWB = 4, AW = 5, PW = 8, OW = 11, IW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [NW-1:0]   disp_valid;
  logic [NW*AW-1:0] disp_arch;
  logic [NW*PW-1:0] disp_phys;
  logic [NW*OW-1:0] disp_op;
  logic            disp_ready;
  logic [NW*IW-1:0] disp_idx;
  logic [NWB-1:0]  wb_valid;
  logic [NWB*IW-1:0] wb_idx;
  logic [NWB-1:0]  wb_exc;
  logic            squash_valid;
  logic [IW-1:0]   squash_idx;
  logic [NW-1:0]   commit_valid;
  logic [NW*AW-1:0] commit_arch;
  logic [NW*PW-1:0] commit_phys;
  logic            exc_valid;
  logic [IW-1:0]   exc_idx;
  logic [OW-1:0]   exc_op;
  logic [IW:0]     count;
  logic            empty, full;

  rob_param #(.DEPTH(DEPTH), .NW(NW), .NWB(NWB), .ARCH_W(AW), .PHYS_W(PW),
              .OP_W(OW), .IDX_W(IW)) dut (
    .clk(clk), .reset(reset),
    .disp_valid(disp_valid), .disp_arch(disp_arch), .disp_phys(disp_phys), .disp_op(disp_op),
    .disp_ready(disp_ready), .disp_idx(disp_idx),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_exc(wb_exc),
    .squash_valid(squash_valid), .squash_idx(squash_idx),
    .commit_valid(commit_valid), .commit_arch(commit_arch), .commit_phys(commit_phys),
    .exc_valid(exc_valid), .exc_idx(exc_idx), .exc_op(exc_op),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [AW-1:0] arch;
    logic [PW-1:0] phys;
    logic [OW-1:0] op;
  } rec_t;

  rec_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_tail = 0;
  int   ser = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every retiring lane / exception must match the oldest record.
  always @(negedge clk) begin : monitor
    rec_t r;
    if (!reset) begin
      for (int i = 0; i < NW; i++) begin
        if (commit_valid[i]) begin
          if (i > 0) chk("commit_therm", 32'(commit_valid[i-1]), 32'd1);
          if (q.size() == 0) chk("commit_unexpected", 32'd1, 32'd0);
          else begin
            r = q.pop_front();
            chk("commit_arch", 32'(commit_arch[i*AW +: AW]), 32'(r.arch));
            chk("commit_phys", 32'(commit_phys[i*PW +: PW]), 32'(r.phys));
          end
        end
      end
      if (exc_valid) begin
        if (q.size() == 0) chk("exc_unexpected", 32'd1, 32'd0);
        else begin
          r = q.pop_front();
          chk("exc_idx_sb", 32'(exc_idx), 32'(r.idx));
          chk("exc_op_sb", 32'(exc_op), 32'(r.op));
          q.delete();   // whole ROB flushes at the next edge
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    disp_valid = '0; disp_arch = '0; disp_phys = '0; disp_op = '0;
    wb_valid = '0; wb_idx = '0; wb_exc = '0;
    squash_valid = 1'b0; squash_idx = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
    q.delete();
    exp_tail = 0;
  endtask

  // Drive one dispatch beat; nacc is the hand-counted number of accepted lanes.
  task automatic do_disp(input logic [NW-1:0] mask, input int nacc);
    rec_t r;
    int s;
    for (int i = 0; i < NW; i++) begin
      s = ser + i;
      disp_arch[i*AW +: AW] = AW'(s * 7 + 3);
      disp_phys[i*PW +: PW] = PW'(s + 64);
      disp_op[i*OW +: OW]   = OW'(s * 13 + 165);
    end
    chk("disp_ready", 32'(disp_ready), 32'd1);
    for (int i = 0; i < nacc; i++) begin
      chk("disp_idx", 32'(disp_idx[i*IW +: IW]), 32'((exp_tail + i) % DEPTH));
      s = ser + i;
      r.idx = (exp_tail + i) % DEPTH;
      r.arch = AW'(s * 7 + 3);
      r.phys = PW'(s + 64);
      r.op = OW'(s * 13 + 165);
      q.push_back(r);
    end
    disp_valid = mask;
    tick();
    disp_valid = '0;
    exp_tail = (exp_tail + nacc) % DEPTH;
    ser += NW;
  endtask

  task automatic do_wb(input logic [NWB-1:0] v, input int i0, input int i1,
                       input int i2, input int i3, input logic [NWB-1:0] e);
    wb_valid = v;
    wb_idx = {IW'(i3), IW'(i2), IW'(i1), IW'(i0)};
    wb_exc = e;
    tick();
    wb_valid = '0;
    wb_exc = '0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    reset = 1'b1;
    clear_inputs();

    // Reset defaults and mid-stream reset
    do_reset();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ready", 32'(disp_ready), 32'd1);
    chk("rst_commit", 32'(commit_valid), 32'd0);
    chk("rst_exc", 32'(exc_valid), 32'd0);
    do_disp(4'b1111, 4);
    chk("disp4_count", 32'(count), 32'd4);
    chk("disp4_empty", 32'(empty), 32'd0);
    do_reset();
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_ready", 32'(disp_ready), 32'd1);
    chk("mid_rst_commit", 32'(commit_valid), 32'd0);
    do_wb(4'b0001, 0, 0, 0, 0, 4'b0000);
    chk("stale_wb_commit", 32'(commit_valid), 32'd0);
    chk("stale_wb_count", 32'(count), 32'd0);

    // Out-of-order writeback: 3,1,0 then 2
    do_disp(4'b1111, 4);
    do_wb(4'b0111, 3, 1, 0, 0, 4'b0000);
    chk("ooo_commit_01", 32'(commit_valid), 32'b0011);
    do_wb(4'b0001, 2, 0, 0, 0, 4'b0000);
    chk("ooo_commit_23", 32'(commit_valid), 32'b0011);
    tick();
    chk("ooo_count", 32'(count), 32'd0);
    chk("ooo_empty", 32'(empty), 32'd1);

    // Precise exception on idx 5
    do_reset();
    do_disp(4'b1111, 4);
    do_disp(4'b1111, 4);
    do_wb(4'b1111, 0, 1, 2, 3, 4'b0000);
    chk("exc_pre_commit", 32'(commit_valid), 32'b1111);
    do_wb(4'b0011, 4, 5, 0, 0, 4'b0010);
    chk("exc_commit4", 32'(commit_valid), 32'b0001);
    chk("exc_not_yet", 32'(exc_valid), 32'd0);
    tick();
    chk("exc_valid", 32'(exc_valid), 32'd1);
    chk("exc_idx", 32'(exc_idx), 32'd5);
    chk("exc_commit0", 32'(commit_valid), 32'd0);
    chk("exc_count_before", 32'(count), 32'd3);
    disp_valid = 4'b1111;   // discarded by the flush
    tick();
    disp_valid = '0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_exc_clear", 32'(exc_valid), 32'd0);
    do_wb(4'b0001, 6, 0, 0, 0, 4'b0000);
    chk("flush_wb6_commit", 32'(commit_valid), 32'd0);
    chk("flush_wb6_count", 32'(count), 32'd0);
    exp_tail = 5;
    do_disp(4'b0001, 1);
    chk("redisp_count", 32'(count), 32'd1);
    chk("redisp_not_done", 32'(commit_valid), 32'd0);
    do_wb(4'b0001, 5, 0, 0, 0, 4'b0000);
    chk("redisp_commit", 32'(commit_valid), 32'b0001);
    tick();
    chk("redisp_empty", 32'(empty), 32'd1);

    // Squash with concurrent commit: head=2, tail=10, squash_idx=4
    do_reset();
    do_disp(4'b1111, 4);
    do_disp(4'b1111, 4);
    do_disp(4'b0011, 2);
    chk("sq_pre_count", 32'(count), 32'd10);
    do_wb(4'b0011, 0, 1, 0, 0, 4'b0000);
    do_wb(4'b0001, 2, 0, 0, 0, 4'b0000);
    chk("sq_commit2", 32'(commit_valid), 32'b0001);
    assert (((4 - 2) % DEPTH) < (10 - 2)) else $error("squash_idx names a non-valid entry");
    squash_valid = 1'b1;
    squash_idx = 4'd4;
    disp_valid = 4'b1111;   // discarded in the squash cycle
    for (int k = 0; k < 5; k++) void'(q.pop_back());
    tick();
    squash_valid = 1'b0;
    disp_valid = '0;
    chk("sq_count", 32'(count), 32'd2);
    chk("sq_tail", 32'(disp_idx[IW-1:0]), 32'd5);
    exp_tail = 5;
    do_wb(4'b0001, 7, 0, 0, 0, 4'b0000);
    chk("sq_wb7_commit", 32'(commit_valid), 32'd0);
    chk("sq_wb7_count", 32'(count), 32'd2);
    do_wb(4'b0011, 3, 4, 0, 0, 4'b0000);
    chk("sq_commit34", 32'(commit_valid), 32'b0011);
    tick();
    chk("sq_empty", 32'(empty), 32'd1);

    // Sparse dispatch mask 1011: only lanes 0-1 taken
    do_disp(4'b1011, 2);
    chk("sparse_count", 32'(count), 32'd2);
    do_wb(4'b1111, 5, 6, 7, 8, 4'b0000);
    chk("sparse_commit", 32'(commit_valid), 32'b0011);
    tick();
    chk("sparse_empty", 32'(count), 32'd0);

    // Fill, back-pressure and wrap
    do_reset();
    for (int k = 0; k < 4; k++) do_disp(4'b1111, 4);
    chk("fill_count", 32'(count), 32'd16);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_ready", 32'(disp_ready), 32'd0);
    disp_valid = 4'b1111;   // refused while full
    tick();
    disp_valid = '0;
    chk("fill_refused", 32'(count), 32'd16);
    do_wb(4'b1111, 0, 1, 2, 3, 4'b0000);
    tick();
    chk("ret4_count", 32'(count), 32'd12);
    chk("ret4_ready", 32'(disp_ready), 32'd1);
    chk("ret4_full", 32'(full), 32'd0);
    do_disp(4'b1111, 4);   // wraps: indices 0..3
    chk("wrap_full", 32'(full), 32'd1);
    do_wb(4'b1111, 4, 5, 6, 7, 4'b0000);
    do_wb(4'b1111, 8, 9, 10, 11, 4'b0000);
    do_wb(4'b1111, 12, 13, 14, 15, 4'b0000);
    do_wb(4'b1111, 0, 1, 2, 3, 4'b0000);
    repeat (3) tick();
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_empty", 32'(empty), 32'd1);
    chk("sb_leftover", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
